// File: rtl/contador_monitor.sv
// Shadows an up/down/load counter and flags steps that break the predicted sequence.
// Tracks sync state, classifies each observed step, and keeps a saturating error count.
module contador_monitor #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             con,
    input  logic             cup,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic [ERRW-1:0]  err_count,
    output logic [1:0]       mode,
    output logic             synced
);

    localparam logic [1:0] S_UNSYNC = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_JUMP = 2'b11;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1    = '1;
    localparam logic [ERRW-1:0]  ERR_MAX = '1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] r_prev;
    logic             r_mismatch;
    logic [ERRW-1:0]  r_err;
    logic [1:0]       r_mode;
    logic             r_synced;

    logic [WIDTH-1:0] w_pred;
    logic [WIDTH-1:0] w_delta;
    logic [1:0]       w_step;
    logic             w_miss;
    logic [1:0]       w_next_state;

    // load wins over count-enable
    always_comb begin
        w_pred = count_in;
        if (load) begin
            w_pred = data_in;
        end else if (con && cup) begin
            w_pred = count_in + ONE;
        end else if (con) begin
            w_pred = count_in - ONE;
        end
    end

    assign w_delta = count_in - r_prev;

    always_comb begin
        w_step = M_JUMP;
        if (w_delta == '0) begin
            w_step = M_HOLD;
        end else if (w_delta == ONE) begin
            w_step = M_UP;
        end else if (w_delta == ALL1) begin
            w_step = M_DOWN;
        end
    end

    assign w_miss = (r_state != S_UNSYNC) && (count_in != r_expected);

    always_comb begin
        w_next_state = S_UNSYNC;
        case (r_state)
            S_UNSYNC: w_next_state = S_TRACK;
            S_TRACK,
            S_ERROR:  w_next_state = w_miss ? S_ERROR : S_TRACK;
            default:  w_next_state = S_UNSYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_UNSYNC;
            r_expected <= '0;
            r_prev     <= '0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
            r_mode     <= M_HOLD;
            r_synced   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_expected <= w_pred;
            r_prev     <= count_in;
            r_mismatch <= w_miss;
            r_synced   <= (w_next_state == S_TRACK);
            if (r_state != S_UNSYNC) begin
                r_mode <= w_step;
            end
            if (w_miss && (r_err != ERR_MAX)) begin
                r_err <= r_err + ERRW'(1);
            end
        end
    end

    assign expected  = r_expected;
    assign mismatch  = r_mismatch;
    assign err_count = r_err;
    assign mode      = r_mode;
    assign synced    = r_synced;

endmodule

// File: tb/tb_contador_monitor.sv
// Scoreboard bench for contador_monitor: a bench-side model pushes the
// expected outputs per driven edge; they are popped and compared after the edge.
module tb_contador_monitor;

    localparam int W = 4;
    localparam int E = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] count_in;
    logic [W-1:0] data_in;
    logic         load;
    logic         con;
    logic         cup;
    logic [W-1:0] expected;
    logic         mismatch;
    logic [E-1:0] err_count;
    logic [1:0]   mode;
    logic         synced;

    contador_monitor #(.WIDTH(W), .ERRW(E)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .data_in   (data_in),
        .load      (load),
        .con       (con),
        .cup       (cup),
        .expected  (expected),
        .mismatch  (mismatch),
        .err_count (err_count),
        .mode      (mode),
        .synced    (synced)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] exp;
        logic         mis;
        logic [E-1:0] err;
        logic [1:0]   mode;
        logic         syn;
    } res_t;

    res_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int           m_state;
    logic [W-1:0] m_exp;
    logic [W-1:0] m_prev;
    logic         m_mis;
    logic [E-1:0] m_err;
    logic [1:0]   m_mode;
    logic [W-1:0] cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] c,
        input logic ld, input logic [W-1:0] d, input logic en,
        input logic up);
        if (ld) return d;
        if (en && up) return c + W'(1);
        if (en) return c - W'(1);
        return c;
    endfunction

    function automatic logic [1:0] classify(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] dl;
        dl = b - a;
        if (dl == '0) return 2'b00;
        if (dl == W'(1)) return 2'b01;
        if (dl == {W{1'b1}}) return 2'b10;
        return 2'b11;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_exp   = '0;
        m_prev  = '0;
        m_mis   = 1'b0;
        m_err   = '0;
        m_mode  = 2'b00;
        q.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_exp"},  32'(expected),  32'd0);
        chk({tag, "_mis"},  32'(mismatch),  32'd0);
        chk({tag, "_err"},  32'(err_count), 32'd0);
        chk({tag, "_mode"}, 32'(mode),      32'd0);
        chk({tag, "_syn"},  32'(synced),    32'd0);
    endtask

    task automatic drive(input logic [W-1:0] cin, input logic ld,
                         input logic [W-1:0] din, input logic en,
                         input logic up);
        res_t r;
        count_in = cin;
        load     = ld;
        data_in  = din;
        con      = en;
        cup      = up;
        if (m_state == 0) begin
            m_mis   = 1'b0;
            m_state = 1;
        end else begin
            m_mis  = (cin != m_exp);
            m_mode = classify(m_prev, cin);
            if (m_mis && m_err != {E{1'b1}}) m_err = m_err + E'(1);
            m_state = m_mis ? 2 : 1;
        end
        m_prev = cin;
        m_exp  = ref_next(cin, ld, din, en, up);
        q.push_back('{exp: m_exp, mis: m_mis, err: m_err,
                      mode: m_mode, syn: (m_state == 1)});
        @(posedge clk);
        #1;
        r = q.pop_front();
        chk("expected",  32'(expected),  32'(r.exp));
        chk("mismatch",  32'(mismatch),  32'(r.mis));
        chk("err_count", 32'(err_count), 32'(r.err));
        chk("mode",      32'(mode),      32'(r.mode));
        chk("synced",    32'(synced),    32'(r.syn));
    endtask

    task automatic run(input int n, input logic ld, input logic [W-1:0] din,
                       input logic en, input logic up);
        for (int i = 0; i < n; i++) begin
            drive(cnt, ld, din, en, up);
            cnt = ref_next(cnt, ld, din, en, up);
        end
    endtask

    initial begin
        logic [E-1:0] sat_tab [5];
        sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b0;
        count_in = '0;
        data_in = '0;
        load = 1'b0;
        con = 1'b0;
        cup = 1'b0;
        model_reset();
        #12;
        check_reset("por");
        @(negedge clk);
        rst = 1'b1;
        cnt = '0;

        // count up 0..7, then hold at 8
        run(8, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("up_exp8", 32'(expected), 32'd8);
        chk("up_mode", 32'(mode), 32'd1);
        run(3, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("hold_exp", 32'(expected), 32'd8);
        chk("hold_mode", 32'(mode), 32'd0);
        run(2, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("resume_exp", 32'(expected), 32'd10);
        run(3, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("down_exp", 32'(expected), 32'd7);
        chk("down_mode", 32'(mode), 32'd2);
        run(1, 1'b1, 4'd1, 1'b1, 1'b0);
        chk("load_exp", 32'(expected), 32'd1);
        run(1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("jump_mode", 32'(mode), 32'd3);

        // wrap up through 15->0 and down through 0->15
        run(1, 1'b1, 4'd14, 1'b0, 1'b0);
        run(4, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("wrap_up_mode", 32'(mode), 32'd1);
        run(4, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("wrap_dn_mode", 32'(mode), 32'd2);
        chk("wrap_err", 32'(err_count), 32'd0);

        // load of count+1 while counting up looks like a plain up-step
        run(1, 1'b1, cnt + W'(1), 1'b1, 1'b1);
        run(1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("ldup_mode", 32'(mode), 32'd1);

        // fault injection: 5 observed while 3 predicted
        run(1, 1'b1, 4'd2, 1'b0, 1'b0);
        run(1, 1'b0, 4'd0, 1'b1, 1'b1);
        drive(4'd5, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("fault_mis", 32'(mismatch), 32'd1);
        chk("fault_err", 32'(err_count), 32'd1);
        chk("fault_syn", 32'(synced), 32'd0);
        cnt = 4'd6;
        run(1, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("resync_mis", 32'(mismatch), 32'd0);
        chk("resync_syn", 32'(synced), 32'd1);

        // asynchronous reset away from any edge
        #2;
        rst = 1'b0;
        #1;
        check_reset("midrst1");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt = 4'd9;
        run(2, 1'b0, 4'd0, 1'b1, 1'b1);

        // five back-to-back mismatches saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(m_exp + W'(5), 1'b0, 4'd0, 1'b0, 1'b0);
            chk("sat_mis", 32'(mismatch), 32'd1);
            chk("sat_err", 32'(err_count), 32'(sat_tab[i]));
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset("midrst2");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt = 4'd3;
        run(3, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("post_syn", 32'(synced), 32'd1);
        chk("post_err", 32'(err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
